cmos_split: RTL

Frame-side demultiplexer for the dual-OV5640 path. It takes the merged pixel stream produced by the camera merger, in which each merged line is a camera-0 burst followed by a camera-1 burst, and separates it back into two line-aligned pixel streams. The camera-0 burst is buffered in an internal line RAM and replayed in lockstep with the camera-1 burst. The block sits between the merger output and the per-camera consumers: registration/weighting, or side-by-side display packing.

---
 rtl/cmos_split_if.sv | 25 ++
 rtl/cmos_split.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cmos_split_if.sv
// Pixel-side bundle for cmos_split: merged input stream plus the split,
// line-aligned dual-camera output stream.
interface cmos_split_if #(
  parameter int DATA_W = 16
);
  logic              pixel_vsync;
  logic              pixel_href;
  logic [DATA_W-1:0] pixel_data;
  logic              out_vsync;
  logic              out_de;
  logic [DATA_W-1:0] out0_data;
  logic [DATA_W-1:0] out1_data;
  logic              line_err;
  logic [11:0]       line_cnt;

  modport master (
    output pixel_vsync, pixel_href, pixel_data,
    input  out_vsync, out_de, out0_data, out1_data, line_err, line_cnt
  );

  modport slave (
    input  pixel_vsync, pixel_href, pixel_data,
    output out_vsync, out_de, out0_data, out1_data, line_err, line_cnt
  );
endinterface

// File: rtl/cmos_split.sv
// Splits the merged camera-0/camera-1 line stream into two line-aligned streams:
// camera-0 burst is buffered in a line RAM and replayed alongside camera-1.
module cmos_split #(
  parameter int H_ACTIVE = 640,
  parameter int DATA_W   = 16
) (
  input  logic         cmos_pclk,
  input  logic         sys_rst_n,
  cmos_split_if.slave  pix
);

  localparam int          AW    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam logic [11:0] H_LEN = 12'(H_ACTIVE);

  typedef enum logic [2:0] {IDLE, WAIT0, LINE0, WAIT1, LINE1} state_t;

  state_t            state_q, state_d;
  logic              vsync_q, href_q;
  logic [10:0]       pix_cnt_q, pix_cnt_d;
  logic              vld1_q, vld1_d;
  logic [DATA_W-1:0] pix1_q, pix1_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              vs1_q, out_vsync_q;
  logic              out_de_q, out_de_d;
  logic [DATA_W-1:0] out0_q, out0_d, out1_q, out1_d;
  logic              line_err_q, line_err_d;
  logic [11:0]       line_cnt_q, line_cnt_d;

  logic              fs, be, in_range, len_ok, wr_en, rd_en;
  logic [AW-1:0]     addr;
  logic [DATA_W-1:0] mem [H_ACTIVE];

  always_comb begin
    fs         = pix.pixel_vsync & ~vsync_q;
    be         = ~pix.pixel_href & href_q;
    in_range   = {1'b0, pix_cnt_q} < H_LEN;
    len_ok     = {1'b0, pix_cnt_q} == H_LEN;
    addr       = pix_cnt_q[AW-1:0];
    state_d    = state_q;
    line_err_d = 1'b0;
    line_cnt_d = line_cnt_q;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    vld1_d     = 1'b0;
    pix1_d     = pix1_q;
    out_de_d   = vld1_q;
    out0_d     = out0_q;
    out1_d     = out1_q;

    if (fs || be)
      pix_cnt_d = '0;
    else if (pix.pixel_href && pix_cnt_q != '1)
      pix_cnt_d = pix_cnt_q + 11'd1;
    else
      pix_cnt_d = pix_cnt_q;

    case (state_q)
      IDLE: if (fs) state_d = WAIT0;
      WAIT0, LINE0: begin
        wr_en = pix.pixel_href & in_range;
        if (state_q == WAIT0 && pix.pixel_href) begin
          state_d = LINE0;
        end else if (state_q == LINE0 && be) begin
          if (len_ok) begin
            state_d = WAIT1;
          end else begin
            line_err_d = 1'b1;
            state_d    = WAIT0;
          end
        end
      end
      WAIT1, LINE1: begin
        if (pix.pixel_href && in_range) begin
          rd_en  = 1'b1;
          vld1_d = 1'b1;
          pix1_d = pix.pixel_data;
        end
        if (state_q == WAIT1 && pix.pixel_href) begin
          state_d = LINE1;
        end else if (state_q == LINE1 && be) begin
          if (len_ok) begin
            if (line_cnt_q != '1) line_cnt_d = line_cnt_q + 12'd1;
          end else begin
            line_err_d = 1'b1;
          end
          state_d = WAIT0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start overrides the line FSM and flushes both pipe stages.
    if (fs && state_q != IDLE) begin
      state_d    = WAIT0;
      line_cnt_d = '0;
      line_err_d = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      vld1_d     = 1'b0;
      out_de_d   = 1'b0;
    end

    if (out_de_d) begin
      out0_d = rd_data_q;
      out1_d = pix1_q;
    end
  end

  always_ff @(posedge cmos_pclk) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      // Track vsync through reset so a level already high at release is not a frame start.
      vsync_q     <= pix.pixel_vsync;
      href_q      <= 1'b0;
      pix_cnt_q   <= '0;
      vld1_q      <= 1'b0;
      pix1_q      <= '0;
      vs1_q       <= 1'b0;
      out_vsync_q <= 1'b0;
      out_de_q    <= 1'b0;
      out0_q      <= '0;
      out1_q      <= '0;
      line_err_q  <= 1'b0;
      line_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= pix.pixel_vsync;
      href_q      <= pix.pixel_href;
      pix_cnt_q   <= pix_cnt_d;
      vld1_q      <= vld1_d;
      pix1_q      <= pix1_d;
      vs1_q       <= pix.pixel_vsync;
      out_vsync_q <= vs1_q;
      out_de_q    <= out_de_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      line_err_q  <= line_err_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  always_ff @(posedge cmos_pclk) begin
    if (sys_rst_n && wr_en) mem[addr] <= pix.pixel_data;
    if (sys_rst_n && rd_en) rd_data_q <= mem[addr];
  end

  assign pix.out_vsync = out_vsync_q;
  assign pix.out_de    = out_de_q;
  assign pix.out0_data = out0_q;
  assign pix.out1_data = out1_q;
  assign pix.line_err  = line_err_q;
  assign pix.line_cnt  = line_cnt_q;

endmodule
